// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and data access.
// Data wins by default; a bounded run of data grants forces a fetch grant to avoid starvation.
module mem_port_arbiter #(
  parameter int ADDRESS_LEN  = 32,
  parameter int DATA_LEN     = 32,
  parameter int WAIT_CYCLES  = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDRESS_LEN-1:0] if_addr,
  output logic [DATA_LEN-1:0]    if_rdata,
  output logic                   if_ready,
  input  logic                   mem_rd_req,
  input  logic                   mem_wr_req,
  input  logic [ADDRESS_LEN-1:0] mem_addr,
  input  logic [DATA_LEN-1:0]    mem_wdata,
  output logic [DATA_LEN-1:0]    mem_rdata,
  output logic                   mem_ready,
  output logic                   sram_en,
  output logic                   sram_we,
  output logic [ADDRESS_LEN-1:0] sram_addr,
  output logic [DATA_LEN-1:0]    sram_wdata,
  input  logic [DATA_LEN-1:0]    sram_rdata,
  output logic                   freeze_if,
  output logic                   freeze_mem
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [3:0]             wait_cnt_r;
  logic [3:0]             starve_cnt_r;
  logic                   grant_mem_r;
  logic                   write_r;
  logic [ADDRESS_LEN-1:0] addr_r;
  logic [DATA_LEN-1:0]    wdata_r;
  logic [DATA_LEN-1:0]    if_rdata_r;
  logic [DATA_LEN-1:0]    mem_rdata_r;
  logic                   data_req_s;
  logic                   starved_s;
  logic                   busy_s;
  logic                   last_beat_s;

  assign data_req_s  = mem_rd_req | mem_wr_req;
  assign starved_s   = if_req & (starve_cnt_r == STARVE_MAX);
  assign busy_s      = (state_r == BUSY_IF) | (state_r == BUSY_MEM);
  assign last_beat_s = busy_s & (wait_cnt_r == WAIT_LAST);

  assign if_rdata   = if_rdata_r;
  assign mem_rdata  = mem_rdata_r;
  assign freeze_if  = if_req & ~if_ready;
  assign freeze_mem = data_req_s & ~mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (starved_s) begin
          next_state_s = BUSY_IF;
        end else if (data_req_s) begin
          next_state_s = BUSY_MEM;
        end else if (if_req) begin
          next_state_s = BUSY_IF;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (last_beat_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = state_r;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Grant-time capture keeps the access immune to requester changes while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r   <= 4'd0;
      starve_cnt_r <= 4'd0;
      grant_mem_r  <= 1'b0;
      write_r      <= 1'b0;
      addr_r       <= {ADDRESS_LEN{1'b0}};
      wdata_r      <= {DATA_LEN{1'b0}};
      if_rdata_r   <= {DATA_LEN{1'b0}};
      mem_rdata_r  <= {DATA_LEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (next_state_s == BUSY_MEM) begin
            addr_r      <= mem_addr;
            write_r     <= mem_wr_req;
            wdata_r     <= mem_wr_req ? mem_wdata : {DATA_LEN{1'b0}};
            grant_mem_r <= 1'b1;
            wait_cnt_r  <= 4'd0;
            if (!if_req) begin
              starve_cnt_r <= 4'd0;
            end else if (starve_cnt_r != STARVE_MAX) begin
              starve_cnt_r <= starve_cnt_r + 4'd1;
            end
          end else if (next_state_s == BUSY_IF) begin
            addr_r       <= if_addr;
            write_r      <= 1'b0;
            wdata_r      <= {DATA_LEN{1'b0}};
            grant_mem_r  <= 1'b0;
            wait_cnt_r   <= 4'd0;
            starve_cnt_r <= 4'd0;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          if (last_beat_s) begin
            wait_cnt_r <= 4'd0;
            if (!write_r) begin
              if (grant_mem_r) begin
                mem_rdata_r <= sram_rdata;
              end else begin
                if_rdata_r <= sram_rdata;
              end
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = {ADDRESS_LEN{1'b0}};
    sram_wdata = {DATA_LEN{1'b0}};
    if_ready   = 1'b0;
    mem_ready  = 1'b0;
    case (state_r)
      BUSY_IF, BUSY_MEM: begin
        sram_en    = 1'b1;
        sram_we    = write_r;
        sram_addr  = addr_r;
        sram_wdata = write_r ? wdata_r : {DATA_LEN{1'b0}};
      end
      DONE: begin
        if (grant_mem_r) begin
          mem_ready = 1'b1;
        end else begin
          if_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants,
// SRAM beats and completions; a negedge monitor compares them against the DUT.
module tb_mem_port_arbiter;
  localparam int W = 3;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd_req = 1'b0;
  logic        mem_wr_req = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        freeze_if;
  logic        freeze_mem;

  mem_port_arbiter #(.ADDRESS_LEN(32), .DATA_LEN(32), .WAIT_CYCLES(W), .STARVE_LIMIT(L)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .freeze_if(freeze_if), .freeze_mem(freeze_mem)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit is_mem; bit we; logic [31:0] rdata;} cpl_t;
  typedef struct {int cyc; logic [31:0] addr; bit we; logic [31:0] wdata;} beat_t;

  cpl_t         cq[$];
  beat_t        bq[$];
  byte unsigned log_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_run = 0;
  int if_rdy_cnt = 0;
  int mem_rdy_cnt = 0;
  int we_cnt = 0;

  // SRAM word is a function of the address; only the final driven beat carries the true word.
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return a ^ 32'hE3A01005;
  endfunction

  assign sram_rdata = (sram_en && en_run == W - 1) ? sram_word(sram_addr) : ~sram_word(sram_addr);

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    en_run <= sram_en ? en_run + 1 : 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_log(input string name, input string exp);
    string s;
    s = "";
    foreach (log_q[i]) s = $sformatf("%s%c", s, log_q[i]);
    checks++;
    if (s != exp) begin
      failures++;
      $display("FAIL %s: got %s expected %s", name, s, exp);
    end
  endtask

  // Reference model: transaction-level arbitration, evaluated once inputs are settled.
  int          free_at = 0;
  int          starve_m = 0;
  bit          g_if, g_mem, m_we;
  logic [31:0] m_addr, m_wd;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      cq.delete();
      bq.delete();
      starve_m = 0;
      free_at  = cyc + 1;
    end else if (cyc >= free_at) begin
      g_if  = 1'b0;
      g_mem = 1'b0;
      if (if_req && starve_m == L) g_if = 1'b1;
      else if (mem_rd_req || mem_wr_req) g_mem = 1'b1;
      else if (if_req) g_if = 1'b1;
      if (g_mem) begin
        starve_m = if_req ? ((starve_m < L) ? starve_m + 1 : L) : 0;
        m_addr = mem_addr;
        m_we   = mem_wr_req;
        m_wd   = mem_wr_req ? mem_wdata : 32'h0;
      end else if (g_if) begin
        starve_m = 0;
        m_addr = if_addr;
        m_we   = 1'b0;
        m_wd   = 32'h0;
      end
      if (g_if || g_mem) begin
        for (int k = 1; k <= W; k++) bq.push_back('{cyc + k, m_addr, m_we, m_wd});
        cq.push_back('{cyc + W + 1, g_mem, m_we, m_we ? 32'h0 : sram_word(m_addr)});
        free_at = cyc + W + 2;
      end
    end
  end

  // Monitor: compares every cycle's DUT outputs with what the model scheduled.
  logic [31:0] exp_if_rd = 32'h0;
  logic [31:0] exp_mem_rd = 32'h0;
  bit          x_if_rdy, x_mem_rdy;
  cpl_t        e;
  beat_t       b;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      x_if_rdy  = cq.size() > 0 && cq[0].cyc == cyc && !cq[0].is_mem;
      x_mem_rdy = cq.size() > 0 && cq[0].cyc == cyc && cq[0].is_mem;
      chk("freeze_if", freeze_if, if_req && !x_if_rdy);
      chk("freeze_mem", freeze_mem, (mem_rd_req || mem_wr_req) && !x_mem_rdy);
      if (sram_we) we_cnt++;
      if (if_ready || mem_ready) begin
        log_q.push_back(if_ready ? 8'h49 : 8'h4D);
        if (if_ready) if_rdy_cnt++;
        if (mem_ready) mem_rdy_cnt++;
        if (cq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ready at cycle %0d: got if_ready=%0b mem_ready=%0b required none", cyc, if_ready, mem_ready);
        end else begin
          e = cq.pop_front();
          chk("ready_cycle", cyc, e.cyc);
          chk("ready_port", {if_ready, mem_ready}, e.is_mem ? 2'b01 : 2'b10);
          if (!e.we) begin
            if (e.is_mem) exp_mem_rd = e.rdata;
            else exp_if_rd = e.rdata;
          end
        end
      end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_ready at cycle %0d: got none required pulse due at cycle %0d", cyc, cq[0].cyc);
        void'(cq.pop_front());
      end
      chk("if_rdata", if_rdata, exp_if_rd);
      chk("mem_rdata", mem_rdata, exp_mem_rd);
      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        b = bq.pop_front();
        chk("sram_en", sram_en, 1'b1);
        chk("sram_we", sram_we, b.we);
        chk("sram_addr", sram_addr, b.addr);
        chk("sram_wdata", sram_wdata, b.wdata);
      end else begin
        chk("sram_en_idle", sram_en, 1'b0);
        chk("sram_we_idle", sram_we, 1'b0);
      end
      if (rst) begin
        exp_if_rd  = 32'h0;
        exp_mem_rd = 32'h0;
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, input bit jitter, output int lat);
    int start, n;
    start = cyc;
    n = 0;
    if_req = 1'b1;
    if_addr = a;
    forever begin
      @(negedge clk);
      if (if_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL fetch_timeout: got no if_ready after %0d cycles required within 200", n);
        break;
      end
      @(posedge clk); #1;
      if (jitter) if_addr = $urandom;
    end
    lat = cyc - start;
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_mem(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit jitter, output int lat);
    int start, n;
    start = cyc;
    n = 0;
    mem_rd_req = rd;
    mem_wr_req = wr;
    mem_addr = a;
    mem_wdata = d;
    forever begin
      @(negedge clk);
      if (mem_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL mem_timeout: got no mem_ready after %0d cycles required within 200", n);
        break;
      end
      @(posedge clk); #1;
      if (jitter) begin
        mem_addr = $urandom;
        mem_wdata = $urandom;
      end
    end
    lat = cyc - start;
    @(posedge clk); #1;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
  endtask

  task automatic rand_fetches(input int n);
    int g, lat;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      do_fetch($urandom, $urandom_range(0, 1) == 1, lat);
    end
  endtask

  task automatic rand_mems(input int n);
    int g, t, lat;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, 3);
      if (g > 0) begin
        repeat (g) @(posedge clk);
        #1;
      end
      t = $urandom_range(0, 2);
      do_mem(t != 1, t != 0, $urandom, $urandom, $urandom_range(0, 1) == 1, lat);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required end of run");
    $fatal(1, "watchdog expired");
  end

  int lat_a, lat_b, rc0, ic0, wc0;
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sram_en", sram_en, 1'b0);
    chk("rst_sram_we", sram_we, 1'b0);
    chk("rst_if_ready", if_ready, 1'b0);
    chk("rst_mem_ready", mem_ready, 1'b0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    chk("rst_sram_wdata", sram_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;

    do_fetch(32'h0, 1'b0, lat_a);
    chk("fetch_latency", lat_a, W + 1);
    chk("fetch_word", if_rdata, 32'hE3A01005);

    log_q.delete();
    fork
      do_fetch(32'h0000_0200, 1'b0, lat_a);
      do_mem(1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b0, lat_b);
    join
    check_log("both_order", "MI");
    chk("both_mem_latency", lat_b, W + 1);
    chk("both_if_latency", lat_a, 2 * W + 3);

    wc0 = we_cnt;
    rc0 = mem_rdy_cnt;
    do_mem(1'b0, 1'b1, 32'h0000_0100, 32'hDEADBEEF, 1'b1, lat_b);
    chk("write_we_cycles", we_cnt - wc0, W);
    chk("write_ready_count", mem_rdy_cnt - rc0, 1);

    wc0 = we_cnt;
    rc0 = mem_rdy_cnt;
    do_mem(1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0, lat_b);
    chk("rdwr_we_cycles", we_cnt - wc0, W);
    chk("rdwr_ready_count", mem_rdy_cnt - rc0, 1);

    log_q.delete();
    fork
      begin
        for (int i = 0; i < 2; i++) do_fetch(32'h0000_1000 + 32'(i * 4), 1'b0, lat_a);
      end
      begin
        for (int j = 0; j < 9; j++) do_mem(1'b1, 1'b0, 32'h0000_2000 + 32'(j * 4), 32'h0, 1'b0, lat_b);
      end
    join
    check_log("starvation_order", "MMMMIMMMMIM");

    repeat (2) @(posedge clk);
    #1;
    rc0 = mem_rdy_cnt;
    mem_rd_req = 1'b1;
    mem_addr = 32'h0000_0040;
    @(posedge clk); #1;
    mem_rd_req = 1'b0;
    mem_addr = 32'h0000_0FFF;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("dropped_req_ready_count", mem_rdy_cnt - rc0, 1);

    rc0 = mem_rdy_cnt;
    ic0 = if_rdy_cnt;
    mem_rd_req = 1'b1;
    mem_addr = 32'h0000_0080;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_rd_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sram_en", sram_en, 1'b0);
    chk("midrst_mem_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;
    repeat (W + 3) @(posedge clk);
    #1;
    chk("midrst_no_ready", mem_rdy_cnt - rc0, 0);
    do_fetch(32'h0000_0500, 1'b0, lat_a);
    chk("midrst_fetch_latency", lat_a, W + 1);
    chk("midrst_fetch_count", if_rdy_cnt - ic0, 1);

    fork
      rand_fetches(40);
      rand_mems(60);
    join

    repeat (W + 10) @(posedge clk);
    #1;
    chk("completions_drained", cq.size(), 0);
    chk("beats_drained", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_LEN, default 32, meaning the width of every address port.
REQ-002 The block SHALL have parameter DATA_LEN, default 32, meaning the width of every data port.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 3 (legal 1..15), meaning the number of cycles the SRAM is driven per access.
REQ-004 The block SHALL have parameter STARVE_LIMIT, default 4 (legal 1..15), meaning the maximum number of consecutive data grants while a fetch is pending.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 if_req  input  1  fetch read request, held high until if_ready.
REQ-008 if_addr  input  ADDRESS_LEN  fetch address.
REQ-009 if_rdata  output  DATA_LEN  fetched word.
REQ-010 if_ready  output  1  one-cycle fetch completion pulse.
REQ-011 mem_rd_req  input  1  data read request, held high until mem_ready.
REQ-012 mem_wr_req  input  1  data write request, held high until mem_ready.
REQ-013 mem_addr  input  ADDRESS_LEN  data address.
REQ-014 mem_wdata  input  DATA_LEN  write data.
REQ-015 mem_rdata  output  DATA_LEN  read data.
REQ-016 mem_ready  output  1  one-cycle data completion pulse.
REQ-017 sram_en  output  1  SRAM access strobe.
REQ-018 sram_we  output  1  SRAM write enable.
REQ-019 sram_addr  output  ADDRESS_LEN  SRAM address.
REQ-020 sram_wdata  output  DATA_LEN  SRAM write data.
REQ-021 sram_rdata  input  DATA_LEN  SRAM read data, valid on the last driven cycle.
REQ-022 freeze_if  output  1  combinational: if_req & ~if_ready, stalls fetch stage.
REQ-023 freeze_mem  output  1  combinational: (mem_rd_req | mem_wr_req) & ~mem_ready, stalls pipeline behind MEM.

Function
REQ-024 The FSM SHALL have states IDLE, BUSY_IF, BUSY_MEM, DONE.
REQ-025 In IDLE with no request, the FSM SHALL stay in IDLE with sram_en=0.
REQ-026 In IDLE, a pending data request SHALL be granted (to BUSY_MEM) ahead of if_req, except when the starvation rule applies.
REQ-027 Starvation rule: when starve_cnt == STARVE_LIMIT and if_req=1 in IDLE, IF SHALL be granted (to BUSY_IF) regardless of data requests.
REQ-028 starve_cnt SHALL increment by 1 on a data grant with if_req=1, saturating at STARVE_LIMIT.
REQ-029 starve_cnt SHALL clear to 0 on any IF grant, and on a data grant with if_req=0.
REQ-030 On grant, address, wdata and the write flag SHALL be latched; input changes during BUSY SHALL NOT affect the access.
REQ-031 The write flag SHALL be mem_wr_req; if mem_rd_req and mem_wr_req are both high, the write SHALL be performed and the read ignored for that access.
REQ-032 In BUSY_*, sram_en=1 and sram_addr/sram_we/sram_wdata SHALL be driven from latched values for exactly WAIT_CYCLES cycles, tracked by a wait counter.
REQ-033 sram_we SHALL be 1 only for a data write; sram_wdata SHALL be 0 when sram_we=0.
REQ-034 On the last BUSY cycle of a read, sram_rdata SHALL be captured into if_rdata or mem_rdata according to the grantee.
REQ-035 DONE SHALL last one cycle, pulse exactly one of if_ready/mem_ready for the grantee, ignore all requests, and return to IDLE.
REQ-036 Latency: for a request sampled in IDLE at cycle t, ready SHALL be high at cycle t+WAIT_CYCLES+1; the minimum back-to-back period SHALL be WAIT_CYCLES+2 cycles.
REQ-037 if_rdata/mem_rdata SHALL hold their value until the next read completion for that port; a write SHALL NOT alter mem_rdata.
REQ-038 A request dropped before ready (protocol violation) SHALL NOT abort an in-flight access; completion SHALL still pulse ready.

Reset
REQ-039 When rst=1 at a rising edge, the FSM SHALL go to IDLE and starve_cnt and the wait counter SHALL clear, including mid-access.
REQ-040 After reset, sram_en, sram_we, if_ready and mem_ready SHALL be 0, and sram_addr, sram_wdata, if_rdata and mem_rdata SHALL be 0.
REQ-041 An access interrupted by reset SHALL never produce a ready pulse.

Verification
REQ-042 Fetch only, WAIT_CYCLES=3, if_req=1 at cycle 0, sram_rdata=0xE3A01005 -> sram_en high cycles 1-3, if_ready=1 and if_rdata=0xE3A01005 at cycle 4.
REQ-043 if_req and mem_rd_req both high at cycle 0 -> data served first (mem_ready at cycle 4); IF granted at cycle 5 with if_ready at cycle 9.
REQ-044 Write: mem_wr_req=1, addr=0x100, wdata=0xDEADBEEF -> sram_we=1 and sram_wdata=0xDEADBEEF for 3 cycles, mem_ready pulse, mem_rdata unchanged.
REQ-045 Starvation: mem_rd_req and if_req held high continuously, STARVE_LIMIT=4 -> 4 data grants, then 1 IF grant, then the counter restarts.
REQ-046 Reset mid-access: rst=1 at cycle 2 of BUSY_MEM -> next cycle IDLE with sram_en=0, mem_ready never pulses, and a subsequent fetch completes normally.
REQ-047 Both mem_rd_req and mem_wr_req high -> a single write access and one mem_ready pulse.
